// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the mips_mem memory responder.
package mips_mem_pkg;

   // Operating mode of the responder: serving the processor or accepting preload words.
   typedef enum logic {
      MEM_RUN  = 1'b0,
      MEM_LOAD = 1'b1
   } mem_state_t;

   // Byte address that maps to word 0 of the array.
   localparam logic [31:0] DEFAULT_MEM_BASE = 32'h8002_0000;

   // Default number of 32-bit words in the array.
   localparam int DEFAULT_MEM_DEPTH = 1024;

endpackage : mips_mem_pkg

// File: rtl/mips_mem_decode.sv
// Byte address to word index decode for one processor port.
// An access hits when it is word aligned and falls inside the window
// [base_addr, base_addr + 4*depth_words). The subtraction wraps, so any
// address below base_addr lands far above the window and misses.
module mips_mem_decode
   import mips_mem_pkg::*;
#(
   parameter logic [31:0] base_addr   = DEFAULT_MEM_BASE,
   parameter int          depth_words = DEFAULT_MEM_DEPTH
) (
   input  logic [31:0]                    addr_i,
   output logic                           hit_o,
   output logic [$clog2(depth_words)-1:0] idx_o
);

   localparam int          IW      = $clog2(depth_words);
   localparam logic [31:0] DEPTH_L = 32'(depth_words);

   logic [31:0] off_s;

   // Offset into the window, word-range check and word index extraction.
   always_comb begin
      off_s = addr_i - base_addr;
      hit_o = ({2'b00, off_s[31:2]} < DEPTH_L) && (addr_i[1:0] == 2'b00);
      idx_o = off_s[IW+1:2];
   end

endmodule : mips_mem_decode

// File: rtl/mips_mem.sv
// Memory responder for the processor instruction and data ports, with a
// preload port used to fill the array before the processor runs.
// Read data and error flags are registered every cycle (one cycle latency).
// The array has a single write port shared by data writes (RUN) and
// preload writes (LOAD); the state makes them mutually exclusive.
// Array contents are not reset and survive a reset pulse.
module mips_mem
   import mips_mem_pkg::*;
#(
   parameter logic [31:0] base_addr   = DEFAULT_MEM_BASE,
   parameter int          depth_words = DEFAULT_MEM_DEPTH
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [31:0]                    instr_addr,
   output logic [31:0]                    instr_out,
   output logic                           instr_err,
   input  logic [31:0]                    data_addr,
   input  logic                           data_rd_wr,
   input  logic [31:0]                    data_in,
   output logic [31:0]                    data_out,
   output logic                           data_err,
   input  logic                           load_en,
   input  logic                           load_valid,
   input  logic [$clog2(depth_words)-1:0] load_addr,
   input  logic [31:0]                    load_data,
   output logic                           load_ready
);

   localparam int IW = $clog2(depth_words);

   mem_state_t  state_q, state_d;
   logic        load_ready_q, load_ready_d;
   logic [31:0] instr_out_q, instr_out_d;
   logic        instr_err_q, instr_err_d;
   logic [31:0] data_out_q, data_out_d;
   logic        data_err_q, data_err_d;

   logic [31:0] mem_q [depth_words];

   logic          instr_hit_s, data_hit_s;
   logic [IW-1:0] instr_idx_s, data_idx_s;
   logic          mem_we_s;
   logic [IW-1:0] mem_widx_s;
   logic [31:0]   mem_wdata_s;

   mips_mem_decode #(
      .base_addr   (base_addr),
      .depth_words (depth_words)
   ) u_instr_dec (
      .addr_i (instr_addr),
      .hit_o  (instr_hit_s),
      .idx_o  (instr_idx_s)
   );

   mips_mem_decode #(
      .base_addr   (base_addr),
      .depth_words (depth_words)
   ) u_data_dec (
      .addr_i (data_addr),
      .hit_o  (data_hit_s),
      .idx_o  (data_idx_s)
   );

   // Mode transitions follow load_en; load_ready mirrors the next mode so it is registered.
   always_comb begin
      state_d = state_q;
      case (state_q)
         MEM_RUN: begin
            if (load_en) state_d = MEM_LOAD;
            else         state_d = MEM_RUN;
         end
         MEM_LOAD: begin
            if (!load_en) state_d = MEM_RUN;
            else          state_d = MEM_LOAD;
         end
         default: state_d = MEM_RUN;
      endcase
      load_ready_d = (state_d == MEM_LOAD);
   end

   // Next read data and error flags; in LOAD the processor sees zeros and no errors.
   always_comb begin
      instr_out_d = 32'h0000_0000;
      instr_err_d = 1'b0;
      data_out_d  = 32'h0000_0000;
      data_err_d  = 1'b0;
      case (state_q)
         MEM_RUN: begin
            instr_out_d = instr_hit_s ? mem_q[instr_idx_s] : 32'h0000_0000;
            instr_err_d = !instr_hit_s;
            if (data_rd_wr) begin
               data_out_d = data_hit_s ? mem_q[data_idx_s] : 32'h0000_0000;
            end else begin
               data_out_d = 32'h0000_0000;
            end
            data_err_d = !data_hit_s;
         end
         default: begin
            instr_out_d = 32'h0000_0000;
            instr_err_d = 1'b0;
            data_out_d  = 32'h0000_0000;
            data_err_d  = 1'b0;
         end
      endcase
   end

   // Single array write port: data writes in RUN, preload words in LOAD, nothing while reset is held.
   always_comb begin
      mem_we_s    = 1'b0;
      mem_widx_s  = data_idx_s;
      mem_wdata_s = data_in;
      if (!reset) begin
         mem_we_s = 1'b0;
      end else begin
         case (state_q)
            MEM_RUN: begin
               mem_we_s    = !data_rd_wr && data_hit_s;
               mem_widx_s  = data_idx_s;
               mem_wdata_s = data_in;
            end
            MEM_LOAD: begin
               mem_we_s    = load_valid && load_ready_q;
               mem_widx_s  = load_addr;
               mem_wdata_s = load_data;
            end
            default: begin
               mem_we_s = 1'b0;
            end
         endcase
      end
   end

   // Control and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= MEM_RUN;
         load_ready_q <= 1'b0;
         instr_out_q  <= 32'h0000_0000;
         instr_err_q  <= 1'b0;
         data_out_q   <= 32'h0000_0000;
         data_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         load_ready_q <= load_ready_d;
         instr_out_q  <= instr_out_d;
         instr_err_q  <= instr_err_d;
         data_out_q   <= data_out_d;
         data_err_q   <= data_err_d;
      end
   end

   // Storage array; reads above see the pre-edge contents, giving read-before-write on collisions.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[mem_widx_s] <= mem_wdata_s;
      end
   end

   assign instr_out  = instr_out_q;
   assign instr_err  = instr_err_q;
   assign data_out   = data_out_q;
   assign data_err   = data_err_q;
   assign load_ready = load_ready_q;

endmodule : mips_mem

// File: doc/mips_mem.md
Name: mips_mem

Overview:
- Memory responder on the far end of the processor's instruction and data ports.
- Serves word reads on the instruction port, and word reads/writes on the data port using the processor's data_rd_wr convention (1 = read, 0 = write).
- Provides a preload port that a bench or boot loader uses to fill the array before the processor runs.
- Flags misaligned and out-of-window accesses.

Parameters:
- base_addr, 32'h8002_0000, byte address mapped to word 0 of the array.
- depth_words, 1024, number of 32-bit words (power of two, at least 4).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- instr_addr  in  32  byte address from processor fetch.
- instr_out  out  32  instruction word to processor instr_in.
- instr_err  out  1  registered flag: last instruction access was misaligned or out of window.
- data_addr  in  32  byte address from processor data port.
- data_rd_wr  in  1  1 = read, 0 = write.
- data_in  in  32  write data (processor data_out).
- data_out  out  32  read data to processor data_in.
- data_err  out  1  registered flag: last data access was misaligned or out of window.
- load_en  in  1  request preload mode.
- load_valid  in  1  preload word present.
- load_addr  in  $clog2(depth_words)  preload word index (not a byte address).
- load_data  in  32  preload word.
- load_ready  out  1  high while in LOAD state.

Behaviour:
- Reset (reset low, asynchronous):
  - state = RUN.
  - instr_out, data_out = 0.
  - instr_err, data_err, load_ready = 0.
  - Array contents are NOT cleared; they are undefined after power-up and retained across reset.
- Address decode, applied identically to both ports:
  - off = addr - base_addr (32-bit unsigned).
  - hit = (off >> 2) < depth_words and addr[1:0] == 0.
  - The subtraction wraps, so addresses below base_addr are out of window.
- Read latency is 1 cycle. Outputs are registered on every clk edge, continuously, with no enable. The processor holds addresses stable for 5 cycles, so this latency is sufficient.
- RUN state, instruction port:
  - instr_out <= hit ? mem[idx] : 0.
  - instr_err <= !hit.
- RUN state, data port, data_rd_wr = 1:
  - data_out <= hit ? mem[idx] : 0.
  - data_err <= !hit.
- RUN state, data port, data_rd_wr = 0:
  - If hit, mem[idx] <= data_in; otherwise the write is dropped.
  - data_out <= 0.
  - data_err <= !hit.
- Same-word collision (data write and instruction read to the same word in one cycle): instr_out returns the OLD word (read-before-write). The new value is visible from the next cycle.
- The array has exactly one write port. The data write and the preload write are mutually exclusive by state.
- State machine:
  - RUN -> LOAD when load_en = 1 at a clk edge.
  - LOAD -> RUN when load_en = 0 at a clk edge.
  - load_ready = 1 iff state == LOAD; it is registered and asserts the cycle after load_en is sampled.
- LOAD state:
  - On each edge with load_valid && load_ready, mem[load_addr] <= load_data.
  - load_valid without load_ready is ignored; no queuing.
  - Processor ports: reads return 0, writes are dropped, and instr_err/data_err are forced to 0.
- Reset asserted mid-load: returns to RUN immediately. Words already written are kept; an in-flight word on that edge is not written.
- load_addr is exactly index-width, so it cannot be out of range.

Decomposition:
- Package mips_mem_pkg contains:
  - typedef enum logic {MEM_RUN, MEM_LOAD} mem_state_t.
  - Constant DEFAULT_MEM_BASE = 32'h8002_0000.
- One natural sub-module: mips_mem_decode (combinational addr -> {hit, idx}), instantiated twice, once per port.
- Everything else lives in mips_mem.

Test Plan:
- Preload: reset low 2 cycles, then high. Raise load_en. After load_ready rises, write idx0 = 32'h2408_0005 and idx1 = 32'hDEAD_BEEF, then drop load_en. Present instr_addr = 8002_0004 -> instr_out = DEAD_BEEF one cycle later, instr_err = 0.
- Data write/read: data_rd_wr = 0, data_addr = 8002_0010, data_in = 1234_5678 for one cycle. Then data_rd_wr = 1 at the same address -> data_out = 1234_5678 after 1 cycle.
- Errors:
  - data_addr = 8002_0002 read -> data_out = 0, data_err = 1.
  - data_addr = 8001_FFFC (below base) -> data_err = 1.
  - 8002_1000 with depth 1024 -> data_err = 1.
  - A write to 8002_0001 leaves mem[0] unchanged (verify by read-back).
- Collision: instr_addr = data_addr = 8002_0008, mem[2] = AAAA_AAAA; write 5555_5555 -> same-cycle instr_out = AAAA_AAAA, next cycle instr_out = 5555_5555.
- LOAD isolation: in LOAD, processor write to 8002_0000 with data_in = FFFF_FFFF -> after RUN, mem[0] still equals preloaded 2408_0005; data_out = 0 and data_err = 0 while in LOAD.
- Async reset mid-load: assert reset between clk edges while load_valid = 1 -> load_ready, instr_out, data_out and both err flags go to 0 without waiting for a clock edge, and state = RUN. Previously loaded words read back intact.
